// File: rtl/riscv_prog_loader.sv
// riscv_prog_loader: writes a length-prefixed byte-stream program into instruction memory, holding the core in reset until it is loaded.
//   clk, rst_n          clock (rising edge), asynchronous active-low reset
//   start               pulse to begin a load (accepted only when idle or done)
//   in_valid/in_data    host byte stream; in_ready marks the cycles a byte is taken
//   mem_we/addr/wd      instruction memory write port, one pulse per assembled word
//   core_rst            active-high reset to the core, low only after a good load
//   busy, done, err     load in progress / last load ok / last load too long
module riscv_prog_loader #(
  parameter int ADDR_W   = 10,
  parameter int BASE_IDX = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wd,
  output logic              core_rst,
  output logic              busy,
  output logic              done,
  output logic              err
);
  localparam logic [2:0] IDLE = 3'd0, LEN_LO = 3'd1, LEN_HI = 3'd2, WORD = 3'd3, WRITE = 3'd4, DONE = 3'd5;
  localparam logic [16:0] CAP = 17'((1 << ADDR_W) - BASE_IDX);
  logic [2:0]  state;
  logic [7:0]  len_lo;
  logic [15:0] len, wcnt, len_in;
  logic [1:0]  bcnt;
  logic [23:0] asm_r;
  logic        take;
  assign take     = in_valid & in_ready;
  assign len_in   = {in_data, len_lo};
  assign in_ready = state == LEN_LO || state == LEN_HI || state == WORD;
  assign mem_we   = state == WRITE;
  assign busy     = in_ready | mem_we;
  // start is seen combinationally so the core re-enters reset in the very cycle a reload is accepted
  assign done     = state == DONE && !start;
  assign core_rst = state != DONE || start;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      len_lo   <= '0;
      len      <= '0;
      wcnt     <= '0;
      bcnt     <= '0;
      asm_r    <= '0;
      mem_addr <= '0;
      mem_wd   <= '0;
      err      <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: if (start) begin
          state <= LEN_LO;
          err   <= 1'b0;
        end
        LEN_LO: if (take) begin
          len_lo <= in_data;
          state  <= LEN_HI;
        end
        LEN_HI: if (take) begin
          len  <= len_in;
          wcnt <= '0;
          bcnt <= '0;
          if (len_in == 16'd0) state <= DONE;
          else if ({1'b0, len_in} > CAP) begin
            err   <= 1'b1;
            state <= IDLE;
          end else state <= WORD;
        end
        WORD: if (take) begin
          // bytes arrive LSB first, so shifting in from the top leaves byte k at bits [8k+7:8k]
          bcnt  <= bcnt + 2'd1;
          asm_r <= {in_data, asm_r[23:8]};
          if (bcnt == 2'd3) begin
            mem_wd   <= {in_data, asm_r};
            mem_addr <= ADDR_W'(BASE_IDX) + wcnt[ADDR_W-1:0];
            state    <= WRITE;
          end
        end
        WRITE: begin
          wcnt  <= wcnt + 16'd1;
          state <= (wcnt + 16'd1 == len) ? DONE : WORD;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_riscv_prog_loader.sv
// tb_riscv_prog_loader: directed scoreboard bench for riscv_prog_loader with ADDR_W=2, BASE_IDX=0.
module tb_riscv_prog_loader;
  logic        clk = 0, rst_n = 0, start = 0, in_valid = 0;
  logic [7:0]  in_data = 0;
  logic        in_ready, mem_we, core_rst, busy, done, err;
  logic [1:0]  mem_addr;
  logic [31:0] mem_wd;
  int vectors = 0, miscompares = 0, writes = 0;
  logic [33:0] exp_q[$];
  bit gap = 0;

  riscv_prog_loader #(.ADDR_W(2), .BASE_IDX(0)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wd(mem_wd),
    .core_rst(core_rst), .busy(busy), .done(done), .err(err));

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(negedge clk) if (rst_n && mem_we) begin
    logic [33:0] e;
    writes++;
    if (exp_q.size() == 0) begin
      vectors++;
      miscompares++;
      $display("FAIL unexpected_write: got addr %0d data %h expected no write", mem_addr, mem_wd);
    end else begin
      e = exp_q.pop_front();
      check("write", {30'd0, mem_addr, mem_wd}, {30'd0, e});
    end
  end

  task automatic check_reset_outs(input string name);
    check(name, {in_ready, mem_we, mem_addr, mem_wd, core_rst, busy, done, err},
                {1'b0, 1'b0, 2'd0, 32'd0, 1'b1, 1'b0, 1'b0, 1'b0});
  endtask

  task automatic pulse_start();
    logic was_done;
    @(negedge clk);
    was_done = done;
    start = 1;
    #1;
    if (was_done) check("start_in_done", {core_rst, done}, 2'b10);
    @(posedge clk);
    #1 start = 0;
  endtask

  task automatic send(input logic [7:0] b);
    int n = 0;
    @(negedge clk);
    if (gap) @(negedge clk);
    in_valid = 1;
    in_data  = b;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) check("in_ready_timeout", 0, 1);
    @(posedge clk);
    #1 in_valid = 0;
  endtask

  task automatic send_word(input logic [1:0] idx, input logic [31:0] w);
    exp_q.push_back({idx, w});
    for (int i = 0; i < 4; i++) send(w[8*i +: 8]);
  endtask

  task automatic wait_done(input string name);
    int n = 0;
    while (!done && n < 100) begin
      @(negedge clk);
      n++;
    end
    #1 check(name, {done, core_rst, busy, 29'd0, exp_q.size()}, {1'b1, 1'b0, 1'b0, 29'd0, 32'd0});
  endtask

  initial begin
    int w0;
    #12;
    check_reset_outs("reset");
    @(negedge clk) rst_n = 1;
    #1 check_reset_outs("reset_release");

    // program image of three branches, bytes back to back (in_valid stays high through WRITE)
    w0 = writes;
    pulse_start();
    send(8'h03); send(8'h00);
    send_word(0, 32'h00400a63); send_word(1, 32'h00400263); send_word(2, 32'hfe4004e3);
    wait_done("load3_done");
    check("load3_writes", writes - w0, 3);
    check("hold_addr_wd", {mem_addr, mem_wd}, {2'd2, 32'hfe4004e3});

    // same image with in_valid toggling
    w0 = writes;
    gap = 1;
    pulse_start();
    send(8'h03); send(8'h00);
    send_word(0, 32'h00400a63); send_word(1, 32'h00400263); send_word(2, 32'hfe4004e3);
    wait_done("toggle_done");
    check("toggle_writes", writes - w0, 3);
    gap = 0;

    // exactly full capacity
    w0 = writes;
    pulse_start();
    send(8'h04); send(8'h00);
    send_word(0, 32'h11223344); send_word(1, 32'ha5a5a5a5); send_word(2, 32'h00000001); send_word(3, 32'hdeadbeef);
    wait_done("cap_done");
    check("cap_writes", writes - w0, 4);
    check("cap_last_addr", mem_addr, 2'd3);

    // one word too many
    w0 = writes;
    pulse_start();
    send(8'h05); send(8'h00);
    repeat (3) @(negedge clk);
    #1 check("oversize", {err, busy, in_ready, core_rst, done}, 5'b10010);
    check("oversize_writes", writes - w0, 0);

    // start with a byte in IDLE: the 0x07 must not be taken as LEN_LO
    @(negedge clk);
    start = 1; in_valid = 1; in_data = 8'h07;
    #1 check("idle_byte_held", in_ready, 0);
    @(posedge clk);
    #1 begin start = 0; in_valid = 0; end
    #1 check("err_cleared", err, 0);
    w0 = writes;
    send(8'h00); send(8'h00);
    wait_done("zero_len_done");
    check("zero_len_writes", writes - w0, 0);

    // start pulsed mid-word is ignored
    w0 = writes;
    pulse_start();
    send(8'h01); send(8'h00);
    exp_q.push_back({2'd0, 32'hcafe0193});
    send(8'h93); send(8'h01);
    pulse_start();
    #1 check("busy_mid_word", busy, 1);
    send(8'hfe); send(8'hca);
    wait_done("mid_start_done");
    check("mid_start_writes", writes - w0, 1);

    // async reset right after the 6th byte (completes word 0, before its WRITE is sampled)
    pulse_start();
    send(8'h02); send(8'h00);
    send(8'h01); send(8'h02); send(8'h03); send(8'h04);
    rst_n = 0;
    #1 check_reset_outs("async_reset");
    @(negedge clk) rst_n = 1;
    w0 = writes;
    pulse_start();
    send(8'h01); send(8'h00);
    send_word(0, 32'h0000006f);
    wait_done("after_reset_done");
    check("after_reset_writes", writes - w0, 1);

    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
